// File: rtl/mem_store_queue_pc.sv
// In-order store queue with tail-entry coalescing and youngest-match read forwarding.
// Head entry is presented first-word-fall-through on the drain handshake.
module mem_store_queue_pc #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned EDGE_MODE = 1,
  parameter int unsigned COALESCE  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        lk_addr,
  output logic                     lk_hit,
  output logic [DATA_W-1:0]        lk_data,
  output logic                     drain_valid,
  input  logic                     drain_ready,
  output logic [ADDR_W-1:0]        drain_addr,
  output logic [DATA_W-1:0]        drain_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              wr_en_q;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic              empty_c, full_c, wev_c, pop_c, co_c, push_c;
  logic [PTR_W-1:0]  tail_m1_c;

  // Store event, pop, coalesce and push qualification
  always_comb begin
    empty_c   = (count_q == CNT_W'(0));
    full_c    = (count_q == CNT_W'(DEPTH));
    wev_c     = (EDGE_MODE != 0) ? (wr_en & ~wr_en_q) : wr_en;
    pop_c     = ~empty_c & drain_ready;
    tail_m1_c = PTR_W'(tail_q - PTR_W'(1));
    co_c      = (COALESCE != 0) & wev_c & ~empty_c &
                (mem_addr[tail_m1_c] == wr_addr) &
                ~(pop_c & (count_q == CNT_W'(1)));
    push_c    = wev_c & ~co_c & ~full_c;
  end

  // Pointer, occupancy and sticky overflow next state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push_c) tail_d = PTR_W'(tail_q + PTR_W'(1));
    if (pop_c)  head_d = PTR_W'(head_q + PTR_W'(1));
    case ({push_c, pop_c})
      2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
      2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
      default: count_d = count_q;
    endcase
    if (wev_c & ~co_c & full_c) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      wr_en_q <= wr_en;
    end
  end

  // Storage has no reset; occupancy alone decides what is meaningful
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_addr[tail_q] <= wr_addr;
      mem_data[tail_q] <= wr_data;
    end
    if (co_c) mem_data[tail_m1_c] <= wr_data;
  end

  // Forwarding scan oldest to youngest so the last match wins
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = PTR_W'(head_q + PTR_W'(i));
      if ((CNT_W'(i) < count_q) && (mem_addr[idx] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = mem_data[idx];
      end
    end
  end

  assign drain_valid = ~empty_c;
  assign drain_addr  = empty_c ? '0 : mem_addr[head_q];
  assign drain_data  = empty_c ? '0 : mem_data[head_q];
  assign count       = count_q;
  assign full        = full_c;
  assign empty       = empty_c;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_mem_store_queue_pc.sv
// Bench for mem_store_queue_pc (DEPTH=4, edge-triggered stores, coalescing on):
// directed scenarios followed by random traffic against a queue-based reference.
module tb_mem_store_queue_pc;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] lk_addr;
  logic              lk_hit;
  logic [DATA_W-1:0] lk_data;
  logic              drain_valid;
  logic              drain_ready;
  logic [ADDR_W-1:0] drain_addr;
  logic [DATA_W-1:0] drain_data;
  logic [2:0]        count;
  logic              full;
  logic              empty;
  logic              overflow;

  int n_chk  = 0;
  int n_fail = 0;

  ent_t m_q[$];
  logic m_ovf;
  logic m_prev_we;

  mem_store_queue_pc #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .EDGE_MODE(1), .COALESCE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
    .drain_valid(drain_valid), .drain_ready(drain_ready),
    .drain_addr(drain_addr), .drain_data(drain_data),
    .count(count), .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the reference state for the current inputs
  task automatic check_model();
    logic              hit;
    logic [DATA_W-1:0] hd;
    ent_t              h;
    hit = 1'b0;
    hd  = '0;
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (m_q[i].a == lk_addr) begin
        hit = 1'b1;
        hd  = m_q[i].d;
        break;
      end
    end
    h = (m_q.size() > 0) ? m_q[0] : '0;
    check("m_count", 32'(count), 32'(m_q.size()));
    check("m_empty", 32'(empty), 32'(m_q.size() == 0));
    check("m_full", 32'(full), 32'(m_q.size() == DEPTH));
    check("m_valid", 32'(drain_valid), 32'(m_q.size() != 0));
    check("m_daddr", 32'(drain_addr), 32'(h.a));
    check("m_ddata", 32'(drain_data), 32'(h.d));
    check("m_ovf", 32'(overflow), 32'(m_ovf));
    check("m_lkhit", 32'(lk_hit), 32'(hit));
    check("m_lkdata", 32'(lk_data), 32'(hd));
  endtask

  // Advance the reference by one clock using the current inputs
  task automatic model_update();
    logic wev, pop, co, was_full;
    wev      = wr_en && !m_prev_we;
    pop      = (m_q.size() > 0) && drain_ready;
    co       = wev && (m_q.size() > 0) && (m_q[m_q.size()-1].a == wr_addr)
               && !(pop && m_q.size() == 1);
    was_full = (m_q.size() == DEPTH);
    if (co) m_q[m_q.size()-1].d = wr_data;
    if (pop) void'(m_q.pop_front());
    if (wev && !co) begin
      if (was_full) m_ovf = 1'b1;
      else m_q.push_back('{a: wr_addr, d: wr_data});
    end
    m_prev_we = wr_en;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf     = 1'b0;
    m_prev_we = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the next one
  task automatic step(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic rdy, input logic [ADDR_W-1:0] la);
    wr_en       = we;
    wr_addr     = a;
    wr_data     = d;
    drain_ready = rdy;
    lk_addr     = la;
    @(negedge clk);
    check_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    step(1'b1, a, d, 1'b0, 16'h0);
    step(1'b0, a, d, 1'b0, 16'h0);
  endtask

  initial begin
    logic [ADDR_W-1:0] apool [4];
    apool = '{16'h1000, 16'h1001, 16'h2000, 16'h3000};
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    drain_ready = 1'b0; lk_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_valid", 32'(drain_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_lkhit", 32'(lk_hit), 32'd0);
    check("rst_daddr", 32'(drain_addr), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Held strobe gives a single store
    repeat (5) step(1'b1, 16'h2000, 8'h11, 1'b0, 16'h0);
    check("t1_count", 32'(count), 32'd1);
    check("t1_daddr", 32'(drain_addr), 32'h2000);
    check("t1_ddata", 32'(drain_data), 32'h11);
    step(1'b0, 16'h0, 8'h0, 1'b1, 16'h0);

    // Coalescing onto the tail
    store(16'h2004, 8'hAA);
    store(16'h2004, 8'hBB);
    check("t2_count", 32'(count), 32'd1);
    check("t2_ddata", 32'(drain_data), 32'hBB);
    store(16'h2008, 8'hCC);
    check("t2_count2", 32'(count), 32'd2);
    repeat (2) step(1'b0, 16'h0, 8'h0, 1'b1, 16'h0);

    // Fill, overflow, drain in order
    for (int i = 0; i < 5; i++) begin
      store(16'h4000 + 16'(i), 8'(8'h50 + i));
      if (i == 3) check("t3_full", 32'(full), 32'd1);
    end
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t3_order", 32'(drain_addr), 32'(16'h4000 + 16'(i)));
      step(1'b0, 16'h0, 8'h0, 1'b1, 16'h0);
    end
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_ovf_hold", 32'(overflow), 32'd1);

    // Youngest-match forwarding
    store(16'h0100, 8'h01);
    store(16'h0200, 8'h02);
    store(16'h0100, 8'h03);
    lk_addr = 16'h0100; #1;
    check("t4_hit", 32'(lk_hit), 32'd1);
    check("t4_data", 32'(lk_data), 32'h03);
    lk_addr = 16'h0300; #1;
    check("t4_miss", 32'(lk_hit), 32'd0);
    check("t4_mdata", 32'(lk_data), 32'd0);
    repeat (3) step(1'b0, 16'h0, 8'h0, 1'b1, 16'h0);

    // Store to the sole entry while it pops must push, not coalesce
    store(16'h3000, 8'h44);
    step(1'b1, 16'h3000, 8'h55, 1'b1, 16'h0);
    check("t5_count", 32'(count), 32'd1);
    check("t5_ddata", 32'(drain_data), 32'h55);
    step(1'b0, 16'h0, 8'h0, 1'b1, 16'h0);

    // Reset with entries queued
    store(16'h5000, 8'h01);
    store(16'h5001, 8'h02);
    store(16'h5002, 8'h03);
    rst_n = 1'b0; #1;
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_valid", 32'(drain_valid), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    model_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    store(16'h6000, 8'h77);
    check("t6_resume", 32'(drain_data), 32'h77);

    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 1)), apool[$urandom_range(0, 3)], 8'($urandom),
           ($urandom_range(0, 9) < 3), apool[$urandom_range(0, 3)]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
